// File: rtl/lsu_mem_if.sv
// Load/store memory interface: decodes an LSU request, runs one req/gnt/rvalid
// bus transaction and returns load data right-aligned by byte offset.
module lsu_mem_if #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           inst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err_misaligned,
    output logic                  err_illegal,
    output logic [31:0]           ld_data,
    output logic [31:0]           ld_inst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_mis_q, err_mis_d;
    logic                  err_ill_q, err_ill_d;
    logic [31:0]           ld_data_q, ld_data_d;
    logic [31:0]           ld_inst_q, ld_inst_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [1:0]            off_q, off_d;
    logic                  is_load_q, is_load_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_ld;
    logic        is_st;
    logic        illegal;
    logic        misal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    always_comb begin
        opcode  = inst[6:0];
        funct3  = inst[14:12];
        is_ld   = (opcode == 7'b0000011);
        is_st   = (opcode == 7'b0100011);
        illegal = 1'b1;
        if (is_ld && funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111)
            illegal = 1'b0;
        if (is_st && !funct3[2] && funct3[1:0] != 2'b11)
            illegal = 1'b0;
        misal     = 1'b0;
        be_new    = 4'b0000;
        wdata_new = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                misal     = addr[0];
                be_new    = 4'b0011 << addr[1:0];
                wdata_new = {2{wdata[15:0]}};
            end
            2'b10: begin
                misal  = (addr[1:0] != 2'b00);
                be_new = 4'b1111;
            end
            default: begin
                be_new = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        err_mis_d   = 1'b0;
        err_ill_d   = 1'b0;
        ld_data_d   = ld_data_q;
        ld_inst_d   = ld_inst_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        off_d       = off_q;
        is_load_d   = is_load_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ld_inst_d = inst;
                    if (illegal || misal) begin
                        state_d   = DONE;
                        err_ill_d = illegal;
                        err_mis_d = !illegal && misal;
                    end else begin
                        state_d     = REQ;
                        mem_we_d    = is_st;
                        mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                        off_d       = addr[1:0];
                        is_load_d   = is_ld;
                    end
                end
            end
            REQ: begin
                if (mem_gnt)
                    state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                    if (is_load_q)
                        ld_data_d = mem_rdata >> {off_q, 3'b000};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        // Status outputs are registered views of the next state
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        mem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_mis_q   <= 1'b0;
            err_ill_q   <= 1'b0;
            ld_data_q   <= '0;
            ld_inst_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            off_q       <= '0;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_mis_q   <= err_mis_d;
            err_ill_q   <= err_ill_d;
            ld_data_q   <= ld_data_d;
            ld_inst_q   <= ld_inst_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            off_q       <= off_d;
            is_load_q   <= is_load_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_misaligned = err_mis_q;
    assign err_illegal    = err_ill_q;
    assign ld_data        = ld_data_q;
    assign ld_inst        = ld_inst_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;

endmodule
